// File: rtl/shift_pkg.sv
// Shared definitions for the bshift_32 front end.
// Op field is {rotate, left, arith}; rotate ignores the arith bit.
package shift_pkg;

  localparam int unsigned OP_ROT   = 2;
  localparam int unsigned OP_LEFT  = 1;
  localparam int unsigned OP_ARITH = 0;

  localparam logic [2:0] OP_SRL = 3'b000;
  localparam logic [2:0] OP_SRA = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_SLA = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
  localparam logic [2:0] OP_ROL = 3'b110;

endpackage

// File: rtl/bshift_32.sv
// Combinational 32-bit barrel shifter / rotator.
// Ports: a    - operand
//        b    - shift amount (0..31)
//        op   - {rotate, left, arith}
//        q    - result
//        ov   - SLA overflow: a bit differing from the sign was shifted out
//               or into the sign position
//        z    - result is zero
module bshift_32 (
  input  logic [31:0] a,
  input  logic [4:0]  b,
  input  logic [2:0]  op,
  output logic [31:0] q,
  output logic        ov,
  output logic        z
);
  import shift_pkg::*;

  logic [63:0] rot_dbl;
  logic [31:0] back;

  always_comb begin
    q       = a;
    ov      = 1'b0;
    rot_dbl = '0;
    back    = '0;
    if (op[OP_ROT]) begin
      // rotate by shifting a doubled copy and taking the wrapped half
      if (op[OP_LEFT]) begin
        rot_dbl = {a, a} << b;
        q       = rot_dbl[63:32];
      end else begin
        rot_dbl = {a, a} >> b;
        q       = rot_dbl[31:0];
      end
    end else if (op[OP_LEFT]) begin
      q = a << b;
      if (op[OP_ARITH]) begin
        // overflow iff shifting back arithmetically fails to recover a
        back = $unsigned($signed(q) >>> b);
        ov   = (back != a);
      end
    end else if (op[OP_ARITH]) begin
      q = $unsigned($signed(a) >>> b);
    end else begin
      q = a >> b;
    end
    z = (q == '0);
  end

endmodule

// File: rtl/shift_rr_arb2.sv
// Two-way arbiter with round-robin pointer.
// Ports: clk, rst_n  - clock, async active-low reset
//        valid[1:0]  - request valids (bit 0 = P0)
//        accept      - a granted request completed its handshake this cycle
//        fixed_prio  - 1: P0 always wins a conflict
//        grant[1:0]  - one-hot grant (zero when idle)
//        port        - index of the granted port
module shift_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       accept,
  input  logic       fixed_prio,
  output logic [1:0] grant,
  output logic       port
);

  // rr_q = 0 prefers P0 on the next conflict, 1 prefers P1
  logic rr_q;
  logic rr_d;

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = (fixed_prio || !rr_q) ? 2'b01 : 2'b10;
    end
    port = grant[1];
    rr_d = accept ? ~port : rr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/shift_arb.sv
// Two-port arbitrated, two-stage pipelined front end for bshift_32.
// Ports: clk, rst_n, flush          - clock, async reset, sync pipeline clear
//        p0_* / p1_*                - request handshakes (valid/ready) with
//                                     operand a, amount b, op and tag
//        res_valid / res_ready      - registered result handshake
//        res_q, res_ov, res_z       - shifter result and flags
//        res_port, res_tag          - source port and tag of the result
module shift_arb #(
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             p0_valid,
  output logic             p0_ready,
  input  logic [31:0]      p0_a,
  input  logic [4:0]       p0_b,
  input  logic [2:0]       p0_op,
  input  logic [TAG_W-1:0] p0_tag,
  input  logic             p1_valid,
  output logic             p1_ready,
  input  logic [31:0]      p1_a,
  input  logic [4:0]       p1_b,
  input  logic [2:0]       p1_op,
  input  logic [TAG_W-1:0] p1_tag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_q,
  output logic             res_ov,
  output logic             res_z,
  output logic             res_port,
  output logic [TAG_W-1:0] res_tag
);

  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_a_q,     s1_a_d;
  logic [4:0]       s1_b_q,     s1_b_d;
  logic [2:0]       s1_op_q,    s1_op_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
  logic             s1_port_q,  s1_port_d;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q,  out_data_d;
  logic             out_ov_q,    out_ov_d;
  logic             out_z_q,     out_z_d;
  logic             out_port_q,  out_port_d;
  logic [TAG_W-1:0] out_tag_q,   out_tag_d;

  logic [1:0]  grant;
  logic        gport;
  logic        out_en;
  logic        s1_en;
  logic        accept;
  logic [31:0] sh_q;
  logic        sh_ov;
  logic        sh_z;

  assign out_en   = ~out_valid_q | res_ready;
  assign s1_en    = ~s1_valid_q | out_en;
  assign p0_ready = grant[0] & s1_en & ~flush;
  assign p1_ready = grant[1] & s1_en & ~flush;
  assign accept   = p0_ready | p1_ready;

  shift_rr_arb2 u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid      ({p1_valid, p0_valid}),
    .accept     (accept),
    .fixed_prio (FIXED_PRIO != 0),
    .grant      (grant),
    .port       (gport)
  );

  bshift_32 u_shift (
    .a  (s1_a_q),
    .b  (s1_b_q),
    .op (s1_op_q),
    .q  (sh_q),
    .ov (sh_ov),
    .z  (sh_z)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_tag_d   = s1_tag_q;
    s1_port_d  = s1_port_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (s1_en) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_a_d    = gport ? p1_a   : p0_a;
        s1_b_d    = gport ? p1_b   : p0_b;
        s1_op_d   = gport ? p1_op  : p0_op;
        s1_tag_d  = gport ? p1_tag : p0_tag;
        s1_port_d = gport;
      end
    end
  end

  // Result fields only load when S1 actually advances; otherwise they hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ov_d    = out_ov_q;
    out_z_d     = out_z_q;
    out_port_d  = out_port_q;
    out_tag_d   = out_tag_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (out_en) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = sh_q;
        out_ov_d   = sh_ov;
        out_z_d    = sh_z;
        out_port_d = s1_port_q;
        out_tag_d  = s1_tag_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= '0;
      s1_tag_q    <= '0;
      s1_port_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ov_q    <= 1'b0;
      out_z_q     <= 1'b0;
      out_port_q  <= 1'b0;
      out_tag_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      s1_tag_q    <= s1_tag_d;
      s1_port_q   <= s1_port_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ov_q    <= out_ov_d;
      out_z_q     <= out_z_d;
      out_port_q  <= out_port_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign res_valid = out_valid_q;
  assign res_q     = out_data_q;
  assign res_ov    = out_ov_q;
  assign res_z     = out_z_q;
  assign res_port  = out_port_q;
  assign res_tag   = out_tag_q;

endmodule
